// File: rtl/lane_joiner_param.sv
// lane_joiner_param: buffers parallel multi-lane words in a small FIFO and
// emits their lane symbols serially (lane 0 first) on a ready/valid byte
// stream. Each word carries its own link width, so x1..xNUM_LANES links
// share the same block.
// Optional feature macro: LANE_JOINER_REVERSAL_EN adds a per-word lane_rev
// input that emits the active lanes in descending physical order.
module lane_joiner_param #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [NUM_LANES*DATA_W-1:0]                      lane_data,
    input  logic [$clog2(NUM_LANES):0]                       active_lanes,
`ifdef LANE_JOINER_REVERSAL_EN
    input  logic                                             lane_rev,
`endif
    input  logic                                             in_valid,
    output logic                                             in_ready,
    output logic [DATA_W-1:0]                                out_data,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [((NUM_LANES > 1) ? $clog2(NUM_LANES) : 1)-1:0] lane_idx,
    output logic [$clog2(DEPTH+1)-1:0]                       fifo_level
);

    localparam int AL  = $clog2(NUM_LANES) + 1;                      // active_lanes width
    localparam int LW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;    // lane index width
    localparam int AW  = $clog2(DEPTH);                              // FIFO pointer width
    localparam int LVW = $clog2(DEPTH + 1);                          // level width

    typedef enum logic {
        ST_IDLE,
        ST_SERIAL
    } state_e;

    state_e                              state_q;
    logic [AW-1:0]                       wr_ptr_q;
    logic [AW-1:0]                       rd_ptr_q;
    logic [LVW-1:0]                      count_q;
    logic [LVW-1:0]                      count_d;
    logic [LW-1:0]                       lane_cnt_q;

    // Word storage is data-path only and carries no reset; the pointers and
    // level decide what is valid.
    logic [NUM_LANES-1:0][DATA_W-1:0]    mem_data_q  [DEPTH];
    logic [AL-1:0]                       mem_lanes_q [DEPTH];
`ifdef LANE_JOINER_REVERSAL_EN
    logic                                mem_rev_q   [DEPTH];
`endif

    logic                                push;
    logic                                advance;
    logic                                pop;
    logic                                last_lane;
    logic [AL-1:0]                       eff_lanes;
    logic [AL-1:0]                       head_lanes;
    logic [LW-1:0]                       phys_idx;

    assign in_ready   = (count_q != LVW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign out_valid  = (state_q == ST_SERIAL);
    assign fifo_level = count_q;

    // Out-of-range widths (0 or more than NUM_LANES) fall back to full width.
    assign eff_lanes  = ((active_lanes >= AL'(1)) && (active_lanes <= AL'(NUM_LANES)))
                        ? active_lanes : AL'(NUM_LANES);

    assign head_lanes = mem_lanes_q[rd_ptr_q];
    assign last_lane  = (AL'(lane_cnt_q) == (head_lanes - AL'(1)));
    assign advance    = out_valid && out_ready;
    assign pop        = advance && last_lane;

    // Next FIFO level: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LVW'(1);
            2'b01:   count_d = count_q - LVW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: pointers, level, lane counter and the IDLE/SERIAL FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lane_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + AW'(1);
                lane_cnt_q <= '0;
            end else if (advance) begin
                lane_cnt_q <= lane_cnt_q + LW'(1);
            end
            count_q <= count_d;
            case (state_q)
                ST_IDLE: begin
                    if (push) begin
                        state_q <= ST_SERIAL;
                    end
                end
                ST_SERIAL: begin
                    // Next word's lane 0 follows immediately when one is queued.
                    if (count_d == '0) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Word storage write: lane symbols plus the per-word lane attributes.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q]  <= lane_data;
            mem_lanes_q[wr_ptr_q] <= eff_lanes;
`ifdef LANE_JOINER_REVERSAL_EN
            mem_rev_q[wr_ptr_q]   <= lane_rev;
`endif
        end
    end

    // Output mux: map the serial position onto a physical lane and gate to
    // zero while idle.
    always_comb begin
        phys_idx = lane_cnt_q;
`ifdef LANE_JOINER_REVERSAL_EN
        if (mem_rev_q[rd_ptr_q]) begin
            phys_idx = LW'(head_lanes - AL'(1) - AL'(lane_cnt_q));
        end
`endif
        out_data = '0;
        lane_idx = '0;
        if (out_valid) begin
            out_data = mem_data_q[rd_ptr_q][phys_idx];
            lane_idx = phys_idx;
        end
    end

endmodule

// File: tb/tb_lane_joiner_param.sv
// Self-checking bench for lane_joiner_param (NUM_LANES=4, DATA_W=8, DEPTH=4).
module tb_lane_joiner_param;

    localparam int NL    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lane_data;
    logic [2:0]  active_lanes;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  lane_idx;
    logic [2:0]  fifo_level;
`ifdef LANE_JOINER_REVERSAL_EN
    logic        lane_rev;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lane_joiner_param #(
        .NUM_LANES (NL),
        .DATA_W    (DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lane_data    (lane_data),
        .active_lanes (active_lanes),
`ifdef LANE_JOINER_REVERSAL_EN
        .lane_rev     (lane_rev),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .lane_idx     (lane_idx),
        .fifo_level   (fifo_level)
    );

    // Observation vector: {out_valid, out_data, lane_idx, fifo_level, in_ready}
    function automatic logic [14:0] pk(input int v, input int d, input int i,
                                       input int l, input int r);
        return {v[0], d[7:0], i[1:0], l[2:0], r[0]};
    endfunction

    function automatic logic [14:0] obs();
        return {out_valid, out_data, lane_idx, fifo_level, in_ready};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got v=%0b d=%h idx=%0d lvl=%0d rdy=%0b, expected v=%0b d=%h idx=%0d lvl=%0d rdy=%0b",
                     name, act[14], act[13:6], act[5:4], act[3:1], act[0],
                     exp[14], exp[13:6], exp[5:4], exp[3:1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int k);
        logic [31:0] w;
        for (int l = 0; l < 4; l++) w[l*8 +: 8] = 8'(16 * (k + 1) + l);
        return w;
    endfunction

    typedef struct {
        logic [31:0] d;
        logic [2:0]  al;
        logic        iv;
        logic        ordy;
        logic [14:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        int          eff;
        bit          rev;
    } word_t;

    vec_t  tbl[19];
    word_t mq[$];
    word_t nw;
    int    pos;
    int    phys;
    bit    accept;
    logic [14:0] exp_v;

    initial begin
        // Each row: inputs held for one edge, outputs expected just after it.
        tbl[0]  = '{32'h44332211, 3'd4, 1'b1, 1'b1, pk(1, 'h11, 0, 1, 1)};
        tbl[1]  = '{32'h0,        3'd4, 1'b0, 1'b1, pk(1, 'h22, 1, 1, 1)};
        tbl[2]  = '{32'h0,        3'd4, 1'b0, 1'b1, pk(1, 'h33, 2, 1, 1)};
        tbl[3]  = '{32'h0,        3'd4, 1'b0, 1'b1, pk(1, 'h44, 3, 1, 1)};
        tbl[4]  = '{32'h0,        3'd4, 1'b0, 1'b1, pk(0, 0, 0, 0, 1)};
        tbl[5]  = '{32'hDDCCBBAA, 3'd2, 1'b1, 1'b1, pk(1, 'hAA, 0, 1, 1)};
        tbl[6]  = '{32'h000000EE, 3'd1, 1'b1, 1'b1, pk(1, 'hBB, 1, 2, 1)};
        tbl[7]  = '{32'h0,        3'd0, 1'b0, 1'b1, pk(1, 'hEE, 0, 1, 1)};
        tbl[8]  = '{32'h0,        3'd0, 1'b0, 1'b1, pk(0, 0, 0, 0, 1)};
        tbl[9]  = '{32'h04030201, 3'd0, 1'b1, 1'b1, pk(1, 'h01, 0, 1, 1)};
        tbl[10] = '{32'h0,        3'd0, 1'b0, 1'b1, pk(1, 'h02, 1, 1, 1)};
        tbl[11] = '{32'h0,        3'd0, 1'b0, 1'b1, pk(1, 'h03, 2, 1, 1)};
        tbl[12] = '{32'h0,        3'd0, 1'b0, 1'b1, pk(1, 'h04, 3, 1, 1)};
        tbl[13] = '{32'h0,        3'd0, 1'b0, 1'b1, pk(0, 0, 0, 0, 1)};
        tbl[14] = '{32'h08070605, 3'd7, 1'b1, 1'b1, pk(1, 'h05, 0, 1, 1)};
        tbl[15] = '{32'h0,        3'd0, 1'b0, 1'b1, pk(1, 'h06, 1, 1, 1)};
        tbl[16] = '{32'h0,        3'd0, 1'b0, 1'b1, pk(1, 'h07, 2, 1, 1)};
        tbl[17] = '{32'h0,        3'd0, 1'b0, 1'b1, pk(1, 'h08, 3, 1, 1)};
        tbl[18] = '{32'h0,        3'd0, 1'b0, 1'b1, pk(0, 0, 0, 0, 1)};

        reset        = 1'b1;
        lane_data    = '0;
        active_lanes = '0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
`ifdef LANE_JOINER_REVERSAL_EN
        lane_rev     = 1'b0;
`endif
        step();
        step();
        check("reset_state", obs(), pk(0, 0, 0, 0, 1));
        reset = 1'b0;

        // Directed vectors: single word, mixed widths, out-of-range widths
        for (int i = 0; i < 19; i++) begin
            lane_data    = tbl[i].d;
            active_lanes = tbl[i].al;
            in_valid     = tbl[i].iv;
            out_ready    = tbl[i].ordy;
            step();
            check($sformatf("vec%0d", i), obs(), tbl[i].exp);
        end

        // Backpressure: fill to DEPTH, fifth push refused, then drain 16 symbols
        out_ready    = 1'b0;
        active_lanes = 3'd4;
        for (int k = 0; k < 4; k++) begin
            lane_data = word(k);
            in_valid  = 1'b1;
            step();
            check($sformatf("fill%0d", k), obs(), pk(1, 'h10, 0, k + 1, (k < 3) ? 1 : 0));
        end
        lane_data = word(4);
        in_valid  = 1'b1;
        step();
        check("full_ignore", obs(), pk(1, 'h10, 0, 4, 0));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d", i), obs(),
                  pk(1, 16 * (i / 4 + 1) + i % 4, i % 4, 4 - i / 4, (i >= 4) ? 1 : 0));
            step();
        end
        check("drain_idle", obs(), pk(0, 0, 0, 0, 1));

        // Reset in the middle of a word with two more words queued
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lane_data = word(k);
            in_valid  = 1'b1;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("pre_reset", obs(), pk(1, 'h12, 2, 3, 1));
        reset = 1'b1;
        step();
        check("mid_reset", obs(), pk(0, 0, 0, 0, 1));
        reset     = 1'b0;
        lane_data = 32'hA3A2A1A0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("post_reset_start", obs(), pk(1, 'hA0, 0, 1, 1));
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) step();
        check("post_reset_idle", obs(), pk(0, 0, 0, 0, 1));

`ifdef LANE_JOINER_REVERSAL_EN
        // Reversed word: physical lanes 3..0
        lane_data = 32'h44332211;
        lane_rev  = 1'b1;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        lane_rev = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("rev%0d", j), obs(), pk(1, 'h11 * (4 - j), 3 - j, 1, 1));
            step();
        end
        check("rev_idle", obs(), pk(0, 0, 0, 0, 1));
`endif

        // Randomized traffic against a word-queue reference model
        pos = 0;
        for (int c = 0; c < 800; c++) begin
            lane_data    = $urandom;
            active_lanes = 3'($urandom_range(0, 7));
            in_valid     = ($urandom_range(0, 9) < 6);
            out_ready    = ($urandom_range(0, 9) < 7);
`ifdef LANE_JOINER_REVERSAL_EN
            lane_rev     = 1'($urandom_range(0, 1));
`endif
            if (mq.size() == 0) begin
                exp_v = pk(0, 0, 0, 0, 1);
            end else begin
                phys  = mq[0].rev ? (mq[0].eff - 1 - pos) : pos;
                exp_v = pk(1, int'((mq[0].d >> (8 * phys)) & 32'hFF), phys,
                           mq.size(), (mq.size() < DEPTH) ? 1 : 0);
            end
            check($sformatf("rand%0d", c), obs(), exp_v);

            accept = in_valid && (mq.size() < DEPTH);
            if (mq.size() > 0 && out_ready) begin
                pos++;
                if (pos == mq[0].eff) begin
                    void'(mq.pop_front());
                    pos = 0;
                end
            end
            if (accept) begin
                nw.d   = lane_data;
                nw.eff = (active_lanes >= 1 && active_lanes <= NL) ? int'(active_lanes) : NL;
`ifdef LANE_JOINER_REVERSAL_EN
                nw.rev = lane_rev;
`else
                nw.rev = 1'b0;
`endif
                mq.push_back(nw);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_joiner_param.md
Name: lane_joiner_param

Overview:
- Parametrised successor to the fixed 4-lane byte-joining stage in the physical-layer receive path.
- Accepts one parallel word of NUM_LANES lane symbols per handshake and buffers it in a DEPTH-entry word FIFO.
- Emits the symbols serially, lane 0 first, on a ready/valid byte stream.
- Supports a per-word link width (x1..xNUM_LANES), so narrowed links reuse the same block.

Parameters:
- NUM_LANES, 4, number of physical lanes; integer ≥ 1.
- DATA_W, 8, symbol width per lane in bits.
- DEPTH, 4, word FIFO depth; power of two, ≥ 2.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high reset.
- lane_data, input, NUM_LANES*DATA_W, lane k occupies bits [k*DATA_W +: DATA_W].
- active_lanes, input, $clog2(NUM_LANES)+1, number of valid lanes in lane_data; sampled with the word.
- in_valid, input, 1, lane_data and active_lanes are valid.
- in_ready, output, 1, FIFO can accept a word; equals !full.
- out_data, output, DATA_W, current serial symbol.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts out_data.
- lane_idx, output, $clog2(NUM_LANES) (min 1), lane index of the symbol on out_data.
- fifo_level, output, $clog2(DEPTH+1), number of stored words, including the one being serialised.

Behaviour:
- Reset values: fifo_level=0, lane_idx=0, out_valid=0, out_data=0, in_ready=1. FIFO pointers and the lane counter clear.
- Reset mid-word: the partially emitted word and all stored words are discarded. No further symbols from them are emitted.
- Push: in_valid && in_ready at an edge stores {lane_data, eff_lanes} at the write pointer.
  - eff_lanes = active_lanes when 1 ≤ active_lanes ≤ NUM_LANES, otherwise NUM_LANES.
  - Write pointer wraps modulo DEPTH.
- FSM with two states:
  - IDLE (FIFO empty): out_valid=0, out_data=0, lane_idx=0. A push moves the FSM to SERIAL.
  - SERIAL (FIFO non-empty): out_valid=1, out_data = head word lane[lane_idx], combinational mux from registered storage.
  - On out_valid && out_ready:
    - If lane_idx < head eff_lanes-1: lane_idx increments.
    - Else: head is popped, read pointer wraps, lane_idx returns to 0.
    - If the FIFO is then empty, the FSM goes to IDLE. Otherwise the next word's lane 0 is presented the very next cycle, with no bubble.
  - out_ready=0 holds out_data and lane_idx stable.
- Latency: a word pushed into an empty FIFO at edge t shows lane 0 on out_data in the cycle after edge t.
- Throughput: one symbol per cycle while out_ready=1. Per-word cost is eff_lanes cycles.
- Full: in_ready=0 when fifo_level==DEPTH. A push attempt is ignored even if a pop occurs in the same cycle (no pass-through).
- Push and pop in the same cycle with the FIFO not full: fifo_level is unchanged.
- Empty: pop is impossible because out_valid=0.
- in_valid while in_ready=0: the word is not stored; the upstream must hold it.

Optional Feature:
- Macro: LANE_JOINER_REVERSAL_EN.
- When defined, an extra input port lane_rev (1 bit) exists and is stored per word alongside eff_lanes.
  - Words pushed with lane_rev=1 are emitted in reverse physical order: lanes eff_lanes-1 down to 0.
  - lane_idx reports the physical lane number being emitted.
- When undefined: the port is absent and order is always ascending.

Test Plan:
- Reset, then push one word 0x44332211 (NUM_LANES=4, active_lanes=4), out_ready=1 -> out_data 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles, lane_idx 0..3, then out_valid=0 and fifo_level=0.
- Push 0xDDCCBBAA with active_lanes=2, then 0x000000EE with active_lanes=1 -> stream AA, BB, EE with no idle cycle between words.
- Push with active_lanes=0 and active_lanes=7 -> each word emits all 4 lanes.
- Backpressure: out_ready=0, push 5 words -> 4 accepted, in_ready=0, 5th ignored with fifo_level=4. Then out_ready=1 -> 16 symbols in order, in_ready=1 after the first word pops.
- Assert reset after 2 symbols of a 4-lane word with 2 words queued -> next cycle out_valid=0, fifo_level=0, lane_idx=0. The next pushed word starts at lane 0.
- With LANE_JOINER_REVERSAL_EN defined, push 0x44332211 with lane_rev=1 and active_lanes=4 -> 44, 33, 22, 11 with lane_idx 3, 2, 1, 0.
